// File: rtl/hpdcache_pkg.sv
// Shared memory-interface types for the HPDcache write path: request
// metadata, write-data beats, write responses, plus the address-to-word
// helper used by the memory-side responder.
package hpdcache_pkg;

   localparam int unsigned HPDCACHE_MEM_ADDR_WIDTH = 64;
   localparam int unsigned HPDCACHE_MEM_ID_WIDTH   = 8;
   localparam int unsigned HPDCACHE_MEM_LEN_WIDTH  = 8;
   localparam int unsigned HPDCACHE_MEM_DATA_WIDTH = 64;
   localparam int unsigned HPDCACHE_MEM_BE_WIDTH   = HPDCACHE_MEM_DATA_WIDTH / 8;
   localparam int unsigned HPDCACHE_MEM_OFFSET_W   = $clog2(HPDCACHE_MEM_BE_WIDTH);

   typedef logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] hpdcache_mem_addr_t;
   typedef logic [HPDCACHE_MEM_ID_WIDTH-1:0]   hpdcache_mem_id_t;
   typedef logic [HPDCACHE_MEM_LEN_WIDTH-1:0]  hpdcache_mem_len_t;
   typedef logic [HPDCACHE_MEM_DATA_WIDTH-1:0] hpdcache_mem_data_t;
   typedef logic [HPDCACHE_MEM_BE_WIDTH-1:0]   hpdcache_mem_be_t;

   typedef enum logic [1:0] {
      HPDCACHE_MEM_READ   = 2'b00,
      HPDCACHE_MEM_WRITE  = 2'b01,
      HPDCACHE_MEM_ATOMIC = 2'b10
   } hpdcache_mem_command_e;

   typedef enum logic [1:0] {
      HPDCACHE_MEM_RESP_OK  = 2'b00,
      HPDCACHE_MEM_RESP_NOK = 2'b10
   } hpdcache_mem_error_e;

   typedef struct packed {
      hpdcache_mem_addr_t    mem_req_addr;
      hpdcache_mem_len_t     mem_req_len;
      logic [2:0]            mem_req_size;
      hpdcache_mem_id_t      mem_req_id;
      hpdcache_mem_command_e mem_req_command;
      logic                  mem_req_cacheable;
   } hpdcache_mem_req_t;

   typedef struct packed {
      hpdcache_mem_data_t mem_req_w_data;
      hpdcache_mem_be_t   mem_req_w_be;
      logic               mem_req_w_last;
   } hpdcache_mem_req_w_t;

   typedef struct packed {
      logic                mem_resp_w_is_atomic;
      hpdcache_mem_error_e mem_resp_w_error;
      hpdcache_mem_id_t    mem_resp_w_id;
   } hpdcache_mem_resp_w_t;

   // Subset of the request kept while waiting for its data beat
   typedef struct packed {
      hpdcache_mem_addr_t    addr;
      hpdcache_mem_id_t      id;
      hpdcache_mem_len_t     len;
      hpdcache_mem_command_e command;
   } hpdcache_mem_wr_meta_t;

   // Byte address to data-word index; byte-offset bits are discarded
   function automatic hpdcache_mem_addr_t hpdcache_mem_word_index(
      input hpdcache_mem_addr_t addr
   );
      return addr >> HPDCACHE_MEM_OFFSET_W;
   endfunction

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Register-based FIFO without bypass: a pushed entry becomes visible at the
// head on the cycle after the push.
module hpdcache_fifo_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Next pointers and occupancy; pointers wrap at DEPTH (need not be a power of 2)
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_ok) begin
         wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   // Control state; reset empties the FIFO
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry storage; contents are only meaningful behind a valid pointer
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/hpdcache_mem_write_responder.sv
// Memory-side write responder: queues request metadata and data beats
// independently, pairs them in order, performs the byte-enabled RAM write
// and returns one response per request.
module hpdcache_mem_write_responder
   import hpdcache_pkg::*;
#(
   parameter int unsigned REQ_DEPTH  = 4,
   parameter int unsigned DATA_DEPTH = 4,
   parameter int unsigned RAM_WORDS  = 1024,
   localparam int unsigned RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   output logic                                mem_req_write_ready_o,
   input  logic                                mem_req_write_valid_i,
   input  hpdcache_mem_req_t                   mem_req_write_i,
   output logic                                mem_req_write_data_ready_o,
   input  logic                                mem_req_write_data_valid_i,
   input  hpdcache_mem_req_w_t                 mem_req_write_data_i,
   input  logic                                mem_resp_write_ready_i,
   output logic                                mem_resp_write_valid_o,
   output hpdcache_mem_resp_w_t                mem_resp_write_o,
   input  logic [RAM_AW-1:0]                   dbg_rd_addr_i,
   output logic [HPDCACHE_MEM_DATA_WIDTH-1:0]  dbg_rd_data_o,
   output logic [31:0]                         wr_count_o,
   output logic [31:0]                         err_count_o
);

   hpdcache_mem_wr_meta_t meta_in, meta_head;
   hpdcache_mem_req_w_t   beat_head;
   logic                  req_full, req_empty, dat_full, dat_empty;
   logic                  req_push, dat_push;
   logic                  pair;
   hpdcache_mem_addr_t    widx;
   logic                  in_range;
   logic                  wr_err;
   logic                  ram_we;
   logic [RAM_AW-1:0]     ram_idx;

   logic                  resp_valid_q, resp_valid_d;
   hpdcache_mem_id_t      resp_id_q, resp_id_d;
   logic                  resp_err_q, resp_err_d;
   logic [31:0]           wr_count_q, wr_count_d;
   logic [31:0]           err_count_q, err_count_d;
   logic [HPDCACHE_MEM_DATA_WIDTH-1:0] dbg_rd_data_q;
   logic [HPDCACHE_MEM_DATA_WIDTH-1:0] ram_q [RAM_WORDS];

   logic                  unused_req_fields;
   assign unused_req_fields = ^{mem_req_write_i.mem_req_size,
                                mem_req_write_i.mem_req_cacheable};

   // Readies are held low for the whole reset window
   assign mem_req_write_ready_o      = ~req_full & ~rst_i;
   assign mem_req_write_data_ready_o = ~dat_full & ~rst_i;
   assign req_push = mem_req_write_valid_i & mem_req_write_ready_o;
   assign dat_push = mem_req_write_data_valid_i & mem_req_write_data_ready_o;

   // Keep only the request fields needed to execute and answer the write
   always_comb begin
      meta_in         = '0;
      meta_in.addr    = mem_req_write_i.mem_req_addr;
      meta_in.id      = mem_req_write_i.mem_req_id;
      meta_in.len     = mem_req_write_i.mem_req_len;
      meta_in.command = mem_req_write_i.mem_req_command;
   end

   hpdcache_fifo_reg #(
      .WIDTH ($bits(hpdcache_mem_wr_meta_t)),
      .DEPTH (REQ_DEPTH)
   ) u_req_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (req_push),
      .wdata_i (meta_in),
      .full_o  (req_full),
      .pop_i   (pair),
      .rdata_o (meta_head),
      .empty_o (req_empty)
   );

   hpdcache_fifo_reg #(
      .WIDTH ($bits(hpdcache_mem_req_w_t)),
      .DEPTH (DATA_DEPTH)
   ) u_data_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (dat_push),
      .wdata_i (mem_req_write_data_i),
      .full_o  (dat_full),
      .pop_i   (pair),
      .rdata_o (beat_head),
      .empty_o (dat_empty)
   );

   // Pair the two heads when the response slot is free or being drained now;
   // anything other than a single-beat, in-range WRITE is answered with an error
   always_comb begin
      pair     = ~req_empty & ~dat_empty & (~resp_valid_q | mem_resp_write_ready_i);
      widx     = hpdcache_mem_word_index(meta_head.addr);
      in_range = ((widx >> RAM_AW) == '0);
      ram_idx  = widx[RAM_AW-1:0];
      wr_err   = (meta_head.command != HPDCACHE_MEM_WRITE) |
                 (meta_head.len != '0) |
                 ~beat_head.mem_req_w_last |
                 ~in_range;
      ram_we   = pair & ~wr_err;
   end

   // Response slot and saturating activity counters
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_err_d   = resp_err_q;
      wr_count_d   = wr_count_q;
      err_count_d  = err_count_q;
      if (resp_valid_q && mem_resp_write_ready_i) begin
         resp_valid_d = 1'b0;
      end
      if (pair) begin
         resp_valid_d = 1'b1;
         resp_id_d    = meta_head.id;
         resp_err_d   = wr_err;
         if (wr_err) begin
            if (err_count_q != 32'hFFFF_FFFF) err_count_d = err_count_q + 32'd1;
         end else begin
            if (wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
         end
      end
   end

   // Control registers: response valid and counters
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         resp_valid_q <= 1'b0;
         wr_count_q   <= '0;
         err_count_q  <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         wr_count_q   <= wr_count_d;
         err_count_q  <= err_count_d;
      end
   end

   // Response payload; only observed while the valid bit is set
   always_ff @(posedge clk_i) begin
      resp_id_q  <= resp_id_d;
      resp_err_q <= resp_err_d;
   end

   // Byte-enabled RAM write; contents survive reset
   always_ff @(posedge clk_i) begin
      for (int unsigned b = 0; b < HPDCACHE_MEM_BE_WIDTH; b++) begin
         if (ram_we && beat_head.mem_req_w_be[b]) begin
            ram_q[ram_idx][b*8 +: 8] <= beat_head.mem_req_w_data[b*8 +: 8];
         end
      end
   end

   // Registered debug read; a same-cycle write to the same word returns old data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dbg_rd_data_q <= '0;
      end else begin
         dbg_rd_data_q <= ram_q[dbg_rd_addr_i];
      end
   end

   // Output packing
   always_comb begin
      mem_resp_write_o                      = '0;
      mem_resp_write_o.mem_resp_w_is_atomic = 1'b0;
      mem_resp_write_o.mem_resp_w_error     = resp_err_q ? HPDCACHE_MEM_RESP_NOK
                                                         : HPDCACHE_MEM_RESP_OK;
      mem_resp_write_o.mem_resp_w_id        = resp_id_q;
   end

   assign mem_resp_write_valid_o = resp_valid_q;
   assign dbg_rd_data_o          = dbg_rd_data_q;
   assign wr_count_o             = wr_count_q;
   assign err_count_o            = err_count_q;

endmodule
